// File: rtl/hazard_fwd_unit_if.sv
// Bundle between the decode stage and the hazard/forwarding unit.
// The master side drives the ID-stage instruction fields and flush and
// observes stall and the forwarding selects; the slave side is the unit.
interface hazard_fwd_unit_if #(
  parameter int REG_ADDR_WIDTH = 5,
  parameter int CNT_WIDTH      = 16
);
  logic                      id_valid;
  logic [REG_ADDR_WIDTH-1:0] id_rs1;
  logic [REG_ADDR_WIDTH-1:0] id_rs2;
  logic                      id_rs1_used;
  logic                      id_rs2_used;
  logic [REG_ADDR_WIDTH-1:0] id_rd;
  logic                      id_rd_we;
  logic                      id_is_load;
  logic                      flush;
  logic [1:0]                fwd_a_sel;
  logic [1:0]                fwd_b_sel;
  logic                      stall;
  logic [CNT_WIDTH-1:0]      stall_count;

  modport master (
    output id_valid, id_rs1, id_rs2, id_rs1_used, id_rs2_used,
           id_rd, id_rd_we, id_is_load, flush,
    input  fwd_a_sel, fwd_b_sel, stall, stall_count
  );

  modport slave (
    input  id_valid, id_rs1, id_rs2, id_rs1_used, id_rs2_used,
           id_rd, id_rd_we, id_is_load, flush,
    output fwd_a_sel, fwd_b_sel, stall, stall_count
  );
endinterface

// File: rtl/hazard_fwd_unit.sv
// Hazard detection and operand forwarding for a 5-stage in-order pipe.
// Shadows the EX/MEM/WB destination info, raises a one-cycle stall on a
// load-use dependency and selects the EX operand source (RF/MEM/WB).
module hazard_fwd_unit #(
  parameter int REG_ADDR_WIDTH = 5,
  parameter int CNT_WIDTH      = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  hazard_fwd_unit_if.slave bus
);

  typedef logic [REG_ADDR_WIDTH-1:0] reg_t;

  // Producer info carried down the pipe.
  typedef struct packed {
    reg_t rd;
    logic rd_we;
    logic is_load;
  } dst_t;

  // EX slot additionally needs the consumer side.
  typedef struct packed {
    dst_t dst;
    reg_t rs1;
    reg_t rs2;
    logic rs1_used;
    logic rs2_used;
  } ex_t;

  localparam int STAGES = 3;   // [0]=EX [1]=MEM [2]=WB

  logic [STAGES-1:0]    vld_pipe_q, vld_pipe_d;
  ex_t                  ex_q, ex_d;
  dst_t                 mem_q, mem_d;
  dst_t                 wb_q, wb_d;
  logic [CNT_WIDTH-1:0] stall_count_q, stall_count_d;

  logic load_use;
  logic stall;
  logic kill;
  logic [1:0] sel_a, sel_b;

  // Pick the youngest eligible producer of src. A load sitting in MEM has
  // no data yet, so it is skipped here; that case is covered by the stall.
  function automatic logic [1:0] fwd_sel(
    input reg_t src, input logic used, input logic ex_vld,
    input logic mem_vld, input dst_t mem, input logic wb_vld, input dst_t wb
  );
    logic [1:0] sel;
    sel = 2'b00;
    if (ex_vld && used && src != '0) begin
      if (mem_vld && mem.rd_we && !mem.is_load && mem.rd == src)
        sel = 2'b01;
      else if (wb_vld && wb.rd_we && wb.rd == src)
        sel = 2'b10;
    end
    return sel;
  endfunction

  // Load-use detection against the instruction now in EX; flush wins.
  always_comb begin
    load_use = bus.id_valid && vld_pipe_q[0] && ex_q.dst.is_load &&
               ex_q.dst.rd_we && (ex_q.dst.rd != '0) &&
               ((bus.id_rs1_used && bus.id_rs1 == ex_q.dst.rd) ||
                (bus.id_rs2_used && bus.id_rs2 == ex_q.dst.rd));
    stall    = load_use && !bus.flush;
    kill     = load_use || bus.flush;
  end

  // Next slot contents: EX takes ID or a bubble, MEM/WB always advance.
  always_comb begin
    vld_pipe_d = {vld_pipe_q[STAGES-2:0], bus.id_valid && !kill};
    ex_d       = '0;
    if (!kill) begin
      ex_d.dst.rd      = bus.id_rd;
      ex_d.dst.rd_we   = bus.id_rd_we;
      ex_d.dst.is_load = bus.id_is_load;
      ex_d.rs1         = bus.id_rs1;
      ex_d.rs2         = bus.id_rs2;
      ex_d.rs1_used    = bus.id_rs1_used;
      ex_d.rs2_used    = bus.id_rs2_used;
    end
    mem_d = ex_q.dst;
    wb_d  = mem_q;
  end

  // Saturating count of load-use stall cycles.
  always_comb begin
    stall_count_d = stall_count_q;
    if (stall && (stall_count_q != '1))
      stall_count_d = stall_count_q + 1'b1;
  end

  // Forwarding selects come from the registered slots only.
  always_comb begin
    sel_a = fwd_sel(ex_q.rs1, ex_q.rs1_used, vld_pipe_q[0],
                    vld_pipe_q[1], mem_q, vld_pipe_q[2], wb_q);
    sel_b = fwd_sel(ex_q.rs2, ex_q.rs2_used, vld_pipe_q[0],
                    vld_pipe_q[1], mem_q, vld_pipe_q[2], wb_q);
  end

  // Slot and counter state; reset empties every slot.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_pipe_q    <= '0;
      ex_q          <= '0;
      mem_q         <= '0;
      wb_q          <= '0;
      stall_count_q <= '0;
    end else begin
      vld_pipe_q    <= vld_pipe_d;
      ex_q          <= ex_d;
      mem_q         <= mem_d;
      wb_q          <= wb_d;
      stall_count_q <= stall_count_d;
    end
  end

  assign bus.stall       = stall;
  assign bus.fwd_a_sel   = sel_a;
  assign bus.fwd_b_sel   = sel_b;
  assign bus.stall_count = stall_count_q;

endmodule

// File: doc/hazard_fwd_unit.md
HAZARD_FWD_UNIT -- requirements
Module: hazard_fwd_unit

Interface
REQ-001 Parameter: REG_ADDR_WIDTH, default 5, register index width.
REQ-002 Parameter: CNT_WIDTH, default 16, stall counter width.
REQ-003 The block SHALL have one clock and an asynchronous, active-low reset; the ports are clk and rst_n, listed first.
REQ-004 clk  in  1  sole clock; all state updates on rising edge.
REQ-005 rst_n  in  1  asynchronous active-low reset.
REQ-006 id_valid  in  1  ID stage holds a real instruction.
REQ-007 id_rs1, id_rs2  in  REG_ADDR_WIDTH each  ID source register indices.
REQ-008 id_rs1_used, id_rs2_used  in  1 each  corresponding source is actually read.
REQ-009 id_rd  in  REG_ADDR_WIDTH  ID destination index.
REQ-010 id_rd_we  in  1  ID instruction writes id_rd.
REQ-011 id_is_load  in  1  ID instruction is a load.
REQ-012 flush  in  1  branch/jump redirect; kills ID and EX contents.
REQ-013 fwd_a_sel, fwd_b_sel  out  2 each  select for the EX operand 3:1 muxes: 00 register file, 01 MEM result, 10 WB result; 11 never driven.
REQ-014 stall  out  1  hold PC and IF/ID; insert bubble into EX.
REQ-015 stall_count  out  CNT_WIDTH  saturating count of load-use stall cycles.

Function
REQ-016 Internal tracking SHALL hold EX, MEM and WB slots, each with valid, rd, rd_we, is_load; the EX slot also holds rs1, rs2, rs1_used, rs2_used.
REQ-017 Each cycle without stall or flush: ID fields -> EX slot (valid = id_valid), EX -> MEM, MEM -> WB.
REQ-018 Load-use hazard = id_valid & EX.valid & EX.is_load & EX.rd_we & EX.rd != 0 & ((id_rs1_used & id_rs1 == EX.rd) | (id_rs2_used & id_rs2 == EX.rd)).
REQ-019 stall SHALL be combinational, equal to load-use hazard & !flush.
REQ-020 On stall: EX slot loads a bubble (valid = 0); MEM and WB advance normally; ID inputs are expected to be held by upstream.
REQ-021 On flush: EX slot loads a bubble; MEM and WB advance; flush overrides stall in the same cycle.
REQ-022 A load-use stall SHALL last exactly one cycle, because the next cycle has the load in MEM and a bubble in EX.
REQ-023 fwd_a_sel is derived from the registered slots only, with no input-to-output path.
  - 01 if MEM.valid & MEM.rd_we & !MEM.is_load & MEM.rd != 0 & EX.rs1_used & MEM.rd == EX.rs1.
  - else 10 if WB.valid & WB.rd_we & WB.rd != 0 & EX.rs1_used & WB.rd == EX.rs1.
  - else 00.
REQ-024 fwd_b_sel SHALL use the identical rule on EX.rs2 / EX.rs2_used.
REQ-025 MEM SHALL take priority over WB when both match (youngest producer wins).
REQ-026 Register index 0 SHALL never cause forwarding or a stall.
REQ-027 When EX.valid = 0, both sel outputs SHALL be 00.
REQ-028 stall_count SHALL increment by 1 on each cycle where stall = 1, and SHALL saturate at all-ones without wrapping.

Reset
REQ-029 While rst_n = 0 (asynchronous): all slot valid bits clear, all slot fields clear, stall_count = 0.
REQ-030 Consequently stall = 0 and fwd_a_sel = fwd_b_sel = 00 during and immediately after reset.
REQ-031 Reset asserted mid-stall SHALL drop stall in the same cycle; the first post-reset cycle sees empty EX/MEM/WB slots.

Verification
REQ-032 ALU back-to-back: issue add x5 (rd_we = 1), then sub reading rs1 = x5 -> the cycle the sub is in EX has fwd_a_sel = 01 and stall = 0.
REQ-033 Distance-2 and double hit:
  - add x5; nop; use rs2 = x5 -> fwd_b_sel = 10.
  - add x5; add x5; use x5 -> fwd_a_sel = 01 (MEM priority).
REQ-034 Load-use: lw x7, then add reading rs1 = x7 -> stall = 1 for exactly one cycle, stall_count 0 -> 1, EX bubble, then fwd_a_sel = 10 when the add reaches EX.
REQ-035 x0 and unused sources:
  - lw x0, then use x0 -> no stall, sel 00.
  - lw x7, then instruction with rs1 = 7 but rs1_used = 0 -> no stall.
REQ-036 Flush during hazard: lw x7 in EX, dependent in ID, flush = 1 -> stall = 0, EX bubble, stall_count unchanged.
REQ-037 Saturation and reset: with CNT_WIDTH = 2, force 5 stalls -> stall_count holds 3; then assert rst_n = 0 mid-stall -> stall = 0 and stall_count = 0 asynchronously.
